// File: rtl/spike_encoder.sv
// Spike encoder: loads a receptive field of pixels, then streams one gamma-cycle volley of spike times.
// Latency: one clock per accepted pixel to its slot; RUN starts the cycle after the last accept and lasts TIME_PERIOD clocks.
// Backpressure: pix_ready is high only in LOAD; offers in IDLE/RUN are held off. Optional macro SPIKE_THRESH_EN suppresses dim pixels.
module spike_encoder #(
    parameter int TIME_PERIOD     = 8,
    parameter int RECEPTIVE_FIELD = 16,
    parameter int PIXEL_BITS      = 8,
    parameter int THRESHOLD       = 32,
    localparam int TW             = $clog2(TIME_PERIOD)
) (
    input  logic                                clk,
    input  logic                                rst_l,
    input  logic                                en,
    input  logic                                pix_valid,
    input  logic [PIXEL_BITS-1:0]               pix_data,
    output logic                                pix_ready,
    output logic [TW:0]                         time_val,
    output logic [RECEPTIVE_FIELD-1:0][TW:0]    spike_times,
    output logic                                volley_start,
    output logic                                volley_done,
    output logic [15:0]                         volley_cnt
);

    localparam int TVW = TW + 1;
    localparam int IW  = (RECEPTIVE_FIELD > 1) ? $clog2(RECEPTIVE_FIELD) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    // Out-of-range time shown outside RUN so the layer never sees a false end-of-period.
    localparam logic [TW:0] T_OFF    = TVW'(TIME_PERIOD);
    localparam logic [TW:0] T_LAST   = TVW'(TIME_PERIOD - 1);
    localparam logic [TW:0] NO_SPIKE = {1'b1, {TW{1'b0}}};
    localparam logic [IW-1:0] IDX_LAST = IW'(RECEPTIVE_FIELD - 1);

    logic [1:0]                       r_state;
    logic [IW-1:0]                    r_idx;
    logic [TW:0]                      r_time;
    logic [RECEPTIVE_FIELD-1:0][TW:0] r_slots;
    logic [15:0]                      r_volley_cnt;

    logic              w_accept;
    logic              w_last;
    logic              w_end;
    logic [PIXEL_BITS-1:0] w_inv;
    logic [TW-1:0]     w_time;
    logic [TW:0]       w_enc;

    // Handshake and end-of-volley decode come from registered state only.
    assign pix_ready = (r_state == S_LOAD);
    assign w_accept  = pix_valid && pix_ready;
    assign w_last    = w_accept && (r_idx == IDX_LAST);
    assign w_end     = (r_state == S_RUN) && (r_time == T_LAST);

    // Brighter pixel -> earlier spike: invert intensity, keep the top TW bits.
    assign w_inv  = ~pix_data;
    assign w_time = TW'(w_inv >> (PIXEL_BITS - TW));

`ifdef SPIKE_THRESH_EN
    assign w_enc = (pix_data < PIXEL_BITS'(THRESHOLD)) ? NO_SPIKE : {1'b0, w_time};
`else
    assign w_enc = {1'b0, w_time};
`endif

    // Sequencer: IDLE waits for en, LOAD collects the field, RUN counts out the gamma cycle.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_time  <= T_OFF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_LOAD;
                        r_idx   <= '0;
                    end
                end
                S_LOAD: begin
                    // en is deliberately ignored here so a started volley always completes.
                    if (w_last) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_time  <= '0;
                    end else if (w_accept) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_end) begin
                        r_state <= en ? S_LOAD : S_IDLE;
                        r_idx   <= '0;
                        r_time  <= T_OFF;
                    end else begin
                        r_time <= r_time + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= '0;
                    r_time  <= T_OFF;
                end
            endcase
        end
    end

    // Slot store: written only on accept, so the previous volley stays visible until overwritten.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_slots <= {RECEPTIVE_FIELD{NO_SPIKE}};
        end else if (w_accept) begin
            r_slots[r_idx] <= w_enc;
        end
    end

    // Completed-volley counter, advancing at the close of the done cycle and wrapping naturally.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_volley_cnt <= '0;
        end else if (w_end) begin
            r_volley_cnt <= r_volley_cnt + 16'd1;
        end
    end

    assign time_val     = r_time;
    assign spike_times  = r_slots;
    assign volley_start = (r_state == S_RUN) && (r_time == '0);
    assign volley_done  = w_end;
    assign volley_cnt   = r_volley_cnt;

endmodule

// File: doc/spike_encoder.md
SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 SHALL have parameter TIME_PERIOD, default 8: gamma-cycle length in clocks (power of 2); TW = $clog2(TIME_PERIOD).
REQ-002 SHALL have parameter RECEPTIVE_FIELD, default 16: number of spike lines per volley.
REQ-003 SHALL have parameter PIXEL_BITS, default 8: input intensity width (PIXEL_BITS >= TW).
REQ-004 SHALL have parameter THRESHOLD, default 32: minimum intensity that spikes (used only under SPIKE_THRESH_EN).
REQ-005 SHALL have port clk  input  1  the single clock, rising edge.
REQ-006 SHALL have port rst_l  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  level enable for volley streaming.
REQ-008 SHALL have port pix_valid  input  1  pixel offered.
REQ-009 SHALL have port pix_data  input  PIXEL_BITS  pixel intensity.
REQ-010 SHALL have port pix_ready  output  1  pixel accepted this cycle when high together with pix_valid.
REQ-011 SHALL have port time_val  output  TW+1  gamma-cycle time to the layer.
REQ-012 SHALL have port spike_times  output  RECEPTIVE_FIELD x (TW+1)  per line: bit TW = 1 means no spike; bits TW-1:0 = spike time.
REQ-013 SHALL have port volley_start  output  1  one-cycle pulse, first cycle of RUN.
REQ-014 SHALL have port volley_done  output  1  one-cycle pulse, last cycle of RUN.
REQ-015 SHALL have port volley_cnt  output  16  completed-volley counter, wraps 0xFFFF->0.

Function
REQ-016 SHALL implement states IDLE, LOAD, RUN; IDLE->LOAD when en=1; LOAD->RUN on the RECEPTIVE_FIELD-th accepted pixel; RUN->LOAD after time_val = TIME_PERIOD-1 if en=1, else RUN->IDLE.
REQ-017 SHALL assert pix_ready only in LOAD; pix_valid in IDLE/RUN ignored, no data lost or stored.
REQ-018 SHALL write each accepted pixel to slot idx (0 first), idx incrementing per accept, reset to 0 on entering LOAD.
REQ-019 SHALL encode spike time = (2^PIXEL_BITS-1 - pix_data) >> (PIXEL_BITS-TW), bit TW = 0 (brighter = earlier).
REQ-020 SHALL register encoding on accept; spike_times slots hold value through all of RUN, including cycle time_val = TIME_PERIOD-1.
REQ-021 SHALL drive time_val = 0 first RUN cycle, +1 per cycle to TIME_PERIOD-1; time_val = TIME_PERIOD (out-of-range) in IDLE/LOAD so the layer never sees a false end-of-period.
REQ-022 SHALL pulse volley_start with time_val = 0 and volley_done with time_val = TIME_PERIOD-1; volley_cnt increments in the volley_done cycle.
REQ-023 SHALL keep slots from the previous volley visible during LOAD until overwritten.
REQ-024 SHALL, on en falling during LOAD, stay in LOAD until the volley completes (no partial volley dropped); en only gates exit from RUN and IDLE.
REQ-025 SHALL have no combinational path from inputs to outputs except pix_ready (registered-state only).

Reset
REQ-026 SHALL, while rst_l = 0, force state IDLE, idx 0, pix_ready 0, time_val TIME_PERIOD, all spike_times bit TW = 1 with time bits 0, volley_start/volley_done 0, volley_cnt 0.
REQ-027 SHALL, on reset mid-LOAD or mid-RUN, discard the partial volley; after release resume in IDLE.

Configuration
REQ-028 SHALL, with macro SPIKE_THRESH_EN defined, encode pixels with pix_data < THRESHOLD as no spike (bit TW = 1, time bits 0).
REQ-029 SHALL, without SPIKE_THRESH_EN, spike every accepted pixel per REQ-019; THRESHOLD unused.

Verification (TIME_PERIOD=8, PIXEL_BITS=8, RECEPTIVE_FIELD=4, THRESHOLD=32)
REQ-030 SHALL cover: en=1, pixels 255,128,0,64 back-to-back -> spike_times {0,0},{0,3},{0,7},{0,5}; RUN begins next cycle, time_val 0..7, volley_start at 0, volley_done at 7, volley_cnt=1.
REQ-031 SHALL cover: pix_valid held high through RUN -> pix_ready=0 for all 8 RUN cycles, no slot changes; next LOAD accepts from idx 0.
REQ-032 SHALL cover: SPIKE_THRESH_EN defined, pixel 20 -> slot {1,000}; undefined -> slot {0,7}.
REQ-033 SHALL cover: rst_l low at RUN time_val=4 -> time_val=8, all slots {1,000}, volley_cnt unchanged-to-0, state IDLE after release.
REQ-034 SHALL cover: en dropped mid-RUN -> volley completes to time_val=7, then IDLE with time_val=8, pix_ready=0.
REQ-035 SHALL cover: volley_cnt preloaded near 0xFFFF by 65535 volleys (or forced) -> next volley_done wraps it to 0.
